instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 14 +
 rtl/pc_reg.sv | 42 ++++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

    localparam int          PC_INC           = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: redirect load (word aligned) has priority over the +4 step.
// Latency: new value visible one cycle after load_i/inc_i. No backpressure.
module pc_reg
    import fetch_pkg::*;
#(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [D_WIDTH-1:0] load_pc_i,
    input  logic               inc_i,
    output logic [D_WIDTH-1:0] pc_o
);

    localparam logic [D_WIDTH-1:0] ALIGN_MASK = ~D_WIDTH'(3);

    logic [D_WIDTH-1:0] pc_q;
    logic [D_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_pc_i & ALIGN_MASK;
        end else if (inc_i) begin
            // Natural wrap at the top of the address space.
            pc_d = pc_q + D_WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: request, wait for response, hold for decode.
// Latency 3 cycles per instruction best case; decode backpressure holds the word in HOLD.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = D_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [D_WIDTH-1:0] instr,
    output logic [D_WIDTH-1:0] instr_pc,
    input  logic               redirect,
    input  logic [D_WIDTH-1:0] redirect_pc
);

    fetch_state_e       state_q, state_d;
    logic               squash_q, squash_d;
    logic [D_WIDTH-1:0] instr_q, instr_d;
    logic [D_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic [D_WIDTH-1:0] pc;
    logic               pc_inc;

    pc_reg #(
        .D_WIDTH  (D_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (redirect),
        .load_pc_i (redirect_pc),
        .inc_i     (pc_inc),
        .pc_o      (pc)
    );

    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        pc_inc     = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // A redirect that loses the race with gnt leaves a stale response in flight.
                if (imem_gnt) begin
                    state_d  = WAIT;
                    squash_d = redirect;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    squash_d = 1'b0;
                    if (redirect || squash_q) begin
                        state_d = REQ;
                    end else begin
                        state_d    = HOLD;
                        instr_d    = imem_rdata;
                        instr_pc_d = pc;
                    end
                end else if (redirect) begin
                    squash_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (instr_ready) begin
                    state_d = REQ;
                    pc_inc  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            squash_q   <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            squash_q   <= squash_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc;
    assign instr_valid = (state_q == HOLD);
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomised and directed bench for instr_fetch against a transaction-level fetch model.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    instr_fetch #(.D_WIDTH(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: what the fetch unit is doing, as a set of booleans rather than states.
    logic [31:0] m_pc;
    bit          m_ask, m_pend, m_drop, m_have;
    logic [31:0] m_held, m_held_pc;

    task automatic model_reset();
        m_pc = RST_PC; m_ask = 0; m_pend = 0; m_drop = 0; m_have = 0;
        m_held = '0; m_held_pc = '0;
    endtask

    task automatic model_step(input logic g, input logic rv, input logic [31:0] rd,
                              input logic rdy, input logic redir, input logic [31:0] rpc);
        if (redir) begin
            if ((m_ask && g) || (m_pend && !rv)) begin
                m_pend = 1; m_drop = 1; m_ask = 0;
            end else begin
                m_ask = 1; m_pend = 0; m_drop = 0;
            end
            m_have = 0;
            m_pc = rpc & 32'hFFFF_FFFC;
        end else if (m_ask) begin
            if (g) begin m_ask = 0; m_pend = 1; end
        end else if (m_pend) begin
            if (rv) begin
                m_pend = 0;
                if (m_drop) begin
                    m_drop = 0; m_ask = 1;
                end else begin
                    m_have = 1; m_held = rd; m_held_pc = m_pc;
                end
            end
        end else if (m_have) begin
            if (rdy) begin m_have = 0; m_pc = m_pc + 32'd4; m_ask = 1; end
        end else begin
            m_ask = 1;
        end
    endtask

    logic        o_req, o_valid;
    logic [31:0] o_addr, o_instr, o_ipc;

    task automatic cyc(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
        @(negedge clk);
        imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        instr_ready = rdy; redirect = redir; redirect_pc = rpc;
        #1;
        o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid;
        o_instr = instr; o_ipc = instr_pc;
        check_val("m_req",   {31'd0, o_req},   {31'd0, m_ask});
        check_val("m_addr",  o_addr,           m_pc);
        check_val("m_valid", {31'd0, o_valid}, {31'd0, m_have});
        check_val("m_instr", o_instr,          m_held);
        check_val("m_ipc",   o_ipc,            m_held_pc);
        @(posedge clk);
        model_step(g, rv, rd, rdy, redir, rpc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; instr_ready = 0; redirect = 0;
        model_reset();
        #1;
        check_val("rst_req",   {31'd0, imem_req},    32'd0);
        check_val("rst_addr",  imem_addr,            RST_PC);
        check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_val("rst_instr", instr,                32'd0);
        check_val("rst_ipc",   instr_pc,             32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    logic [31:0] a_addr [1:10];
    logic        a_req  [1:10];
    logic        a_val  [1:10];
    bit          saw_req;

    initial begin
        do_reset();

        // Back-to-back fetches, everything single-cycle.
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 1, $urandom, 1, 0, 0);
            a_addr[i] = o_addr; a_req[i] = o_req; a_val[i] = o_valid;
        end
        check_val("seq_req1",  {31'd0, a_req[1]}, 32'd0);
        check_val("seq_addr2", a_addr[2], 32'h0);
        check_val("seq_addr5", a_addr[5], 32'h4);
        check_val("seq_addr8", a_addr[8], 32'h8);
        check_val("seq_val4",  {31'd0, a_val[4]},  32'd1);
        check_val("seq_val7",  {31'd0, a_val[7]},  32'd1);
        check_val("seq_val10", {31'd0, a_val[10]}, 32'd1);
        check_val("seq_val9",  {31'd0, a_val[9]},  32'd0);

        // Grant withheld.
        do_reset();
        cyc(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check_val("nognt_req",  {31'd0, o_req}, 32'd1);
            check_val("nognt_addr", o_addr, 32'h0);
        end

        // Decode stalls with an instruction held.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h0050_0093, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            check_val("stall_valid", {31'd0, o_valid}, 32'd1);
            check_val("stall_instr", o_instr, 32'h0050_0093);
            check_val("stall_req",   {31'd0, o_req}, 32'd0);
        end
        cyc(0, 0, 0, 1, 0, 0);

        // Redirect while waiting: late response discarded.
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h103);
        cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("squash_req",   {31'd0, o_req}, 32'd1);
        check_val("squash_addr",  o_addr, 32'h100);
        check_val("squash_valid", {31'd0, o_valid}, 32'd0);
        check_val("squash_instr", o_instr, 32'h0050_0093);

        // Wrap at the top of the address space.
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 32'h1234_5678, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        check_val("wrap_ipc", o_ipc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0);
        check_val("wrap_addr", o_addr, 32'h0);
        check_val("wrap_req",  {31'd0, o_req}, 32'd1);

        // Reset in the middle of a transaction, response arrives afterwards.
        cyc(1, 0, 0, 0, 0, 0);
        do_reset();
        saw_req = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 32'h0BAD_0BAD, 1, 0, 0);
            check_val("rstmid_valid", {31'd0, o_valid}, 32'd0);
            if (o_req && !saw_req) begin
                saw_req = 1;
                check_val("rstmid_addr", o_addr, RST_PC);
            end
        end
        check_val("rstmid_sawreq", {31'd0, saw_req}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            if ($urandom_range(0, 499) == 0) do_reset();
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, rpc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
